// File: rtl/vga_pkg.sv
// Default 640x480@60 raster constants and the coordinate type shared with the drawing logic.
package vga_pkg;

  typedef logic [9:0] coord_t;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;
  localparam int DEF_CLK_DIV   = 2;

  localparam int H_TOTAL  = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL  = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int HS_START = DEF_H_VISIBLE + DEF_H_FP;
  localparam int HS_END   = HS_START + DEF_H_SYNC - 1;
  localparam int VS_START = DEF_V_VISIBLE + DEF_V_FP;
  localparam int VS_END   = VS_START + DEF_V_SYNC - 1;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: the generator drives it (master), the display path consumes it (slave).
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic       pixel_en;
  logic       pixel_clk;
  logic       hs;
  logic       vs;
  logic       blank;
  logic       sync;
  coord_t     DrawX;
  coord_t     DrawY;
  logic       frame_start;
  logic [7:0] frame_count;

  modport master (
    output pixel_en, pixel_clk, hs, vs, blank, sync,
    output DrawX, DrawY, frame_start, frame_count
  );

  modport slave (
    input pixel_en, pixel_clk, hs, vs, blank, sync,
    input DrawX, DrawY, frame_start, frame_count
  );

endinterface

// File: rtl/vga_mod_counter.sv
// Modulus-MODULUS up-counter with enable; count_next exposes the value loaded on the next edge.
// Single-cycle update when en is high; no backpressure, wrap flags the terminal count.
module vga_mod_counter #(
  parameter int MODULUS = 800,
  parameter int WIDTH   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_next,
  output logic             wrap
);

  assign wrap = (count == WIDTH'(MODULUS - 1));

  always_comb begin
    count_next = count;
    if (en) begin
      count_next = wrap ? '0 : count + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster generator: pixel-rate strobe from Clk, DrawX/DrawY counters, registered hs/vs/blank.
// Sync/blank share the counters' edge (zero skew); free-running, no backpressure.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter int CLK_DIV   = DEF_CLK_DIV
) (
  input  logic             Clk,
  input  logic             Reset_n,
  vga_timing_gen_if.master vga
);

  localparam int H_LEN = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_LEN = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = $clog2(CLK_DIV);

  localparam coord_t HS_LO = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t HS_HI = coord_t'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam coord_t VS_LO = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t VS_HI = coord_t'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam coord_t X_ACT = coord_t'(H_VISIBLE);
  localparam coord_t Y_ACT = coord_t'(V_VISIBLE);

  if (H_LEN > 1024) begin : g_bad_h_total
    $error("vga_timing_gen: horizontal total exceeds 1024");
  end
  if (V_LEN > 1024) begin : g_bad_v_total
    $error("vga_timing_gen: vertical total exceeds 1024");
  end
  if (CLK_DIV < 2) begin : g_bad_clk_div
    $error("vga_timing_gen: CLK_DIV must be at least 2");
  end

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_next;
  logic             pixel_en;
  logic             pixel_clk;
  logic             hs;
  logic             vs;
  logic             blank;
  logic             frame_start;
  logic [7:0]       frame_count;
  coord_t           draw_x;
  coord_t           draw_y;
  coord_t           x_next;
  coord_t           y_next;
  logic             h_wrap;
  logic             v_wrap;
  logic             v_en;

  assign div_next = (div == DIV_W'(CLK_DIV - 1)) ? '0 : div + DIV_W'(1);

  // pixel_en is registered from the terminal divider count, so it lands CLK_DIV edges after reset
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div       <= '0;
      pixel_en  <= 1'b0;
      pixel_clk <= 1'b0;
    end else begin
      div       <= div_next;
      pixel_en  <= (div == DIV_W'(CLK_DIV - 1));
      pixel_clk <= (div_next >= DIV_W'(CLK_DIV / 2));
    end
  end

  assign v_en = pixel_en & h_wrap;

  vga_mod_counter #(.MODULUS(H_LEN), .WIDTH(10)) u_h_cnt (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .en         (pixel_en),
    .count      (draw_x),
    .count_next (x_next),
    .wrap       (h_wrap)
  );

  vga_mod_counter #(.MODULUS(V_LEN), .WIDTH(10)) u_v_cnt (
    .clk        (Clk),
    .rst_n      (Reset_n),
    .en         (v_en),
    .count      (draw_y),
    .count_next (y_next),
    .wrap       (v_wrap)
  );

  // Decoding the next coordinates keeps hs/vs/blank on the same edge as DrawX/DrawY
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hs          <= 1'b1;
      vs          <= 1'b1;
      blank       <= 1'b0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_start <= 1'b0;
      if (pixel_en) begin
        hs    <= !((x_next >= HS_LO) && (x_next <= HS_HI));
        vs    <= !((y_next >= VS_LO) && (y_next <= VS_HI));
        blank <= (x_next < X_ACT) && (y_next < Y_ACT);
        if (h_wrap && v_wrap) begin
          frame_start <= 1'b1;
          frame_count <= frame_count + 8'd1;
        end
      end
    end
  end

  assign vga.pixel_en    = pixel_en;
  assign vga.pixel_clk   = pixel_clk;
  assign vga.hs          = hs;
  assign vga.vs          = vs;
  assign vga.blank       = blank;
  assign vga.sync        = 1'b0;
  assign vga.DrawX       = draw_x;
  assign vga.DrawY       = draw_y;
  assign vga.frame_start = frame_start;
  assign vga.frame_count = frame_count;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 instance plus two shrunken rasters (one with CLK_DIV=3),
// all compared every cycle against an arithmetic raster model driven by random async resets.
module tb_vga_timing_gen;
  import vga_pkg::*;

  typedef struct packed {
    logic       pe;
    logic       pc;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       sync;
    logic [9:0] x;
    logic [9:0] y;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  typedef struct {
    int hv; int hf; int hsw; int hb;
    int vv; int vf; int vsw; int vb;
    int div;
  } cfg_t;

  typedef struct {
    int         x;
    int         y;
    logic [2:0] hvb;
  } vec_t;

  logic Clk     = 1'b0;
  logic Reset_n = 1'b1;
  always #5 Clk = ~Clk;

  vga_timing_gen_if if_a ();
  vga_timing_gen_if if_b ();
  vga_timing_gen_if if_c ();

  vga_timing_gen dut_a (.Clk(Clk), .Reset_n(Reset_n), .vga(if_a));

  vga_timing_gen #(
    .H_VISIBLE(6), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .CLK_DIV(2)
  ) dut_b (.Clk(Clk), .Reset_n(Reset_n), .vga(if_b));

  vga_timing_gen #(
    .H_VISIBLE(7), .H_FP(1), .H_SYNC(1), .H_BP(2),
    .V_VISIBLE(3), .V_FP(1), .V_SYNC(1), .V_BP(2), .CLK_DIV(3)
  ) dut_c (.Clk(Clk), .Reset_n(Reset_n), .vga(if_c));

  obs_t act_a, act_b, act_c;
  assign act_a = {if_a.pixel_en, if_a.pixel_clk, if_a.hs, if_a.vs, if_a.blank, if_a.sync,
                  if_a.DrawX, if_a.DrawY, if_a.frame_start, if_a.frame_count};
  assign act_b = {if_b.pixel_en, if_b.pixel_clk, if_b.hs, if_b.vs, if_b.blank, if_b.sync,
                  if_b.DrawX, if_b.DrawY, if_b.frame_start, if_b.frame_count};
  assign act_c = {if_c.pixel_en, if_c.pixel_clk, if_c.hs, if_c.vs, if_c.blank, if_c.sync,
                  if_c.DrawX, if_c.DrawY, if_c.frame_start, if_c.frame_count};

  cfg_t cfg_a, cfg_b, cfg_c;
  vec_t tbl [10];
  int   tests = 0;
  int   fails = 0;
  int   k     = 0;   // Clk edges seen since the last reset release
  int   cyc   = 0;
  bit   abort = 1'b0;

  // Position after k edges: n pixel updates have landed, the raster is n mod (htot*vtot)
  function automatic obs_t model(input int kk, input cfg_t c);
    obs_t e;
    int ht, vt, fp, n, pos, x, y;
    e = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    if (kk == 0) return e;
    ht = c.hv + c.hf + c.hsw + c.hb;
    vt = c.vv + c.vf + c.vsw + c.vb;
    fp = ht * vt;
    e.pe = ((kk % c.div) == 0);
    e.pc = ((kk % c.div) >= (c.div / 2));
    n = (kk - 1) / c.div;
    pos = n % fp;
    x = pos % ht;
    y = pos / ht;
    e.x = 10'(x);
    e.y = 10'(y);
    if (n > 0) begin
      e.hs    = !((x >= c.hv + c.hf) && (x < c.hv + c.hf + c.hsw));
      e.vs    = !((y >= c.vv + c.vf) && (y < c.vv + c.vf + c.vsw));
      e.blank = (x < c.hv) && (y < c.vv);
      e.fs    = (((kk - 1) % c.div) == 0) && (pos == 0);
      e.fc    = 8'((n / fp) % 256);
    end
    return e;
  endfunction

  task automatic note_fail();
    fails++;
    if (fails >= 40) abort = 1'b1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
      note_fail();
    end
  endtask

  task automatic chk_obs(input string name, input obs_t got, input obs_t want);
    tests++;
    if (got !== want) begin
      $display("FAIL %s k=%0d: got pe%b pc%b hs%b vs%b bl%b sy%b x%0d y%0d fs%b fc%0d, want pe%b pc%b hs%b vs%b bl%b sy%b x%0d y%0d fs%b fc%0d",
               name, k, got.pe, got.pc, got.hs, got.vs, got.blank, got.sync, got.x, got.y, got.fs, got.fc,
               want.pe, want.pc, want.hs, want.vs, want.blank, want.sync, want.x, want.y, want.fs, want.fc);
      note_fail();
    end
  endtask

  task automatic step();
    @(posedge Clk);
    cyc++;
    if (Reset_n) k++;
    else k = 0;
    @(negedge Clk);
    chk_obs("raster a", act_a, model(k, cfg_a));
    chk_obs("raster b", act_b, model(k, cfg_b));
    chk_obs("raster c", act_c, model(k, cfg_c));
  endtask

  task automatic wait_a(input int x, input int y, input int budget);
    int n = 0;
    while (!(int'(act_a.x) == x && int'(act_a.y) == y) && n < budget && !abort) begin
      step();
      n++;
    end
    chk($sformatf("reach a(%0d,%0d)", x, y),
        int'(int'(act_a.x) == x && int'(act_a.y) == y), 1);
  endtask

  // Asynchronous reset between edges: outputs must clear before the next Clk edge
  task automatic async_reset(input int phase, input int hold);
    @(posedge Clk);
    #(phase);
    Reset_n = 1'b0;
    k = 0;
    #1;
    chk_obs("async reset a", act_a, model(0, cfg_a));
    chk_obs("async reset b", act_b, model(0, cfg_b));
    chk_obs("async reset c", act_c, model(0, cfg_c));
    repeat (hold) step();
    #(phase);
    Reset_n = 1'b1;
  endtask

  initial begin
    int n, line_cyc, pulses, first_k, prev_k, gap, wide, vs_lo, prev_fc;
    bit prev_fs, seen;

    cfg_a = '{DEF_H_VISIBLE, DEF_H_FP, DEF_H_SYNC, DEF_H_BP,
              DEF_V_VISIBLE, DEF_V_FP, DEF_V_SYNC, DEF_V_BP, DEF_CLK_DIV};
    cfg_b = '{6, 1, 2, 1, 4, 1, 2, 1, 2};
    cfg_c = '{7, 1, 1, 2, 3, 1, 1, 2, 3};

    // {DrawX, DrawY, {hs, vs, blank}} on the default raster, in raster order
    tbl[0] = '{639, 0, 3'b111};
    tbl[1] = '{640, 0, 3'b110};
    tbl[2] = '{655, 0, 3'b110};
    tbl[3] = '{656, 0, 3'b010};
    tbl[4] = '{751, 0, 3'b010};
    tbl[5] = '{752, 0, 3'b110};
    tbl[6] = '{799, 0, 3'b110};
    tbl[7] = '{0,   1, 3'b111};
    tbl[8] = '{639, 1, 3'b111};
    tbl[9] = '{640, 1, 3'b110};

    #1 Reset_n = 1'b0;
    repeat (5) step();
    #2 Reset_n = 1'b1;

    n = 0;
    while (!if_a.pixel_en && n < 10) begin
      step();
      n++;
    end
    chk("first pixel_en cycle", n, 2);
    step();
    chk("DrawX after first strobe", int'(if_a.DrawX), 1);

    line_cyc = 0;
    for (int i = 0; i < 10; i++) begin
      wait_a(tbl[i].x, tbl[i].y, 4000);
      if (tbl[i].x == 0 && tbl[i].y == 1) line_cyc = cyc;
      chk($sformatf("hs/vs/blank at (%0d,%0d)", tbl[i].x, tbl[i].y),
          int'({if_a.hs, if_a.vs, if_a.blank}), int'(tbl[i].hvb));
    end

    wait_a(799, 1, 4000);
    repeat (2) step();
    chk("wrap 799->0 with DrawY 1->2", int'({if_a.DrawY, if_a.DrawX}), 2 << 10);
    chk("line length in Clk", cyc - line_cyc, 1600);

    wait_a(300, 2, 2000);
    async_reset(3, 3);

    pulses = 0; first_k = -1; prev_k = 0; gap = 0; wide = 0; vs_lo = 0;
    prev_fs = 1'b0;
    n = 0;
    while (if_b.frame_count != 8'd2 && n < 1000 && !abort) begin
      step();
      n++;
      if (if_b.frame_start) begin
        pulses++;
        if (prev_fs) wide++;
        if (first_k < 0) first_k = k;
        else gap = k - prev_k;
        prev_k = k;
      end
      prev_fs = if_b.frame_start;
      if (pulses == 1 && !if_b.vs) vs_lo++;
    end
    chk("b frame_count after two frames", int'(if_b.frame_count), 2);
    chk("b frame_start pulses", pulses, 2);
    chk("b first frame_start edge after release", first_k, 161);
    chk("b frame_start spacing", gap, 160);
    chk("b wide frame_start pulses", wide, 0);
    chk("b vs low cycles per frame", vs_lo, 40);
    chk("a frame_count after mid-frame reset", int'(if_a.frame_count), 0);

    repeat (3) begin
      repeat ($urandom_range(20, 400)) if (!abort) step();
      async_reset($urandom_range(1, 4), $urandom_range(1, 4));
    end

    seen = 1'b0;
    prev_fc = int'(if_b.frame_count);
    n = 0;
    while (!seen && n < 45000 && !abort) begin
      step();
      n++;
      if (prev_fc == 255 && if_b.frame_count == 8'd0) begin
        seen = 1'b1;
        chk("b frame_start on 255->0 wrap", int'(if_b.frame_start), 1);
      end
      prev_fc = int'(if_b.frame_count);
    end
    chk("b frame_count wrapped", int'(seen), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
